// File: rtl/fe_pkg.sv
// Front-end shared types: RV32I decode enums, operand types, LSU state and
// the misalignment predicate that the trap logic also evaluates.
package fe_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;
  typedef logic [3:0]  RV32I_BYTE_EN_t;

  typedef enum logic [6:0] {
    R_TYPE       = 7'b0110011,
    I_TYPE       = 7'b0010011,
    I_LOAD_TYPE  = 7'b0000011,
    I_JALR_TYPE  = 7'b1100111,
    S_TYPE       = 7'b0100011,
    B_TYPE       = 7'b1100011,
    U_LUI_TYPE   = 7'b0110111,
    U_AUIPC_TYPE = 7'b0010111,
    J_TYPE       = 7'b1101111
  } RV32I_OPCODE_t;

  typedef enum logic [5:0] {
    ADD, SUB, ADDI, LUI, JAL,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } LSU_STATE_t;

  // Halfword accesses need bit 0 clear, word accesses need bits [1:0] clear;
  // byte accesses can never be misaligned.
  function automatic logic lsu_misaligned(input RV32I_INSTRUCTION_MNEMONIC_t mn,
                                          input logic [1:0] off);
    case (mn)
      LH, LHU, SH: return off[0];
      LW, SW:      return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Data-bus handshake between the load/store unit (master) and memory (slave).
interface lsu_bus_ctrl_if;
  import fe_pkg::*;

  logic           dbus_req;
  logic           dbus_we;
  logic [31:0]    dbus_addr;
  RV32I_BYTE_EN_t dbus_be;
  logic [31:0]    dbus_wrdata;
  logic           dbus_ack;
  logic [31:0]    dbus_rddata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wrdata,
    input  dbus_ack, dbus_rddata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wrdata,
    output dbus_ack, dbus_rddata
  );

endinterface

// File: rtl/lsu_bus_ctrl_align.sv
// Byte-lane steering: store byte enables and replicated write data from the
// current instruction, and right-justification of the returned read word.
module lsu_align
  import fe_pkg::*;
(
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic_i,
  input  logic [1:0]                  st_off_i,
  input  RV32I_OPERAND_t              rs2_data_i,
  output RV32I_BYTE_EN_t              st_be_o,
  output RV32I_OPERAND_t              st_wrdata_o,
  input  logic [1:0]                  ld_off_i,
  input  RV32I_OPERAND_t              ld_word_i,
  output RV32I_OPERAND_t              ld_data_o
);

  // Store lane selection; word stores and non-stores pass rs2 straight through.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_be_o     = 4'b1111;
    st_wrdata_o = rs2_data_i;
    case (mnemonic_i)
      SB: begin
        st_be_o     = 4'b0001 << st_off_i;
        st_wrdata_o = {4{rs2_data_i[7:0]}};
      end
      SH: begin
        st_be_o     = 4'b0011 << {st_off_i[1], 1'b0};
        st_wrdata_o = {2{rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0; upper bits are left for
  // the write-data mux to extend.
  assign ld_data_o = ld_word_i >> {ld_off_i, 3'b000};

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: issues one word-aligned req/ack transaction per
// aligned memory instruction, stalls the core while it is outstanding, and
// aborts with bus_err if no ack arrives within TIMEOUT_CYCLES.
module lsu_bus_ctrl
  import fe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  RV32I_OPCODE_t               opcode,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  RV32I_OPERAND_t              alu_out,
  input  RV32I_OPERAND_t              rs2_data,
  lsu_bus_ctrl_if.master              dbus,
  output RV32I_OPERAND_t              bus_rddata,
  output logic                        lsu_stall,
  output logic                        misaligned,
  output logic                        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  LSU_STATE_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           req_q;
  logic           we_q;
  logic [31:0]    addr_q;
  logic [1:0]     off_q;
  RV32I_BYTE_EN_t be_q;
  RV32I_OPERAND_t wrdata_q;
  RV32I_OPERAND_t rddata_q;
  logic           err_q;

  logic           mem_op;
  logic           is_store;
  logic           start;
  RV32I_BYTE_EN_t st_be;
  RV32I_OPERAND_t st_wrdata;
  RV32I_OPERAND_t ld_data;

  assign mem_op     = (opcode == I_LOAD_TYPE) || (opcode == S_TYPE);
  assign is_store   = (opcode == S_TYPE);
  assign misaligned = mem_op && lsu_misaligned(mnemonic, alu_out[1:0]);
  assign start      = mem_op && !misaligned;

  lsu_align u_align (
    .mnemonic_i  (mnemonic),
    .st_off_i    (alu_out[1:0]),
    .rs2_data_i  (rs2_data),
    .st_be_o     (st_be),
    .st_wrdata_o (st_wrdata),
    .ld_off_i    (off_q),
    .ld_word_i   (dbus.dbus_rddata),
    .ld_data_o   (ld_data)
  );

  // Transaction FSM with its counter and all bus/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too so the bus is quiet and the
    // result register reads 0 straight out of reset.
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      off_q    <= '0;
      be_q     <= '0;
      wrdata_q <= '0;
      rddata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading its
      // pre-edge value, independent of statement order.
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            req_q    <= 1'b1;
            we_q     <= is_store;
            addr_q   <= {alu_out[31:2], 2'b00};
            off_q    <= alu_out[1:0];
            be_q     <= is_store ? st_be : 4'b1111;
            wrdata_q <= st_wrdata;
            cnt_q    <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // Ack takes priority over timeout expiry in the same cycle.
          if (dbus.dbus_ack) begin
            if (!we_q) rddata_q <= ld_data;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q    <= 1'b0;
            rddata_q <= '0;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_stall = (state_q == REQ) || ((state_q == IDLE) && start);

  assign dbus.dbus_req    = req_q;
  assign dbus.dbus_we     = we_q;
  assign dbus.dbus_addr   = addr_q;
  assign dbus.dbus_be     = be_q;
  assign dbus.dbus_wrdata = wrdata_q;
  assign bus_rddata       = rddata_q;
  assign bus_err          = err_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: a vector table of single transactions plus
// hand-written reset and ack-outside-REQ sequences.
module tb_lsu_bus_ctrl;
  import fe_pkg::*;

  logic                        clk;
  logic                        rst_n;
  RV32I_OPCODE_t               opcode;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  RV32I_OPERAND_t              alu_out;
  RV32I_OPERAND_t              rs2_data;
  RV32I_OPERAND_t              bus_rddata;
  logic                        lsu_stall;
  logic                        misaligned;
  logic                        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_bus_ctrl_if dbus ();

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mnemonic   (mnemonic),
    .alu_out    (alu_out),
    .rs2_data   (rs2_data),
    .dbus       (dbus),
    .bus_rddata (bus_rddata),
    .lsu_stall  (lsu_stall),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    RV32I_OPCODE_t               op;
    RV32I_INSTRUCTION_MNEMONIC_t mn;
    logic [31:0]                 addr;
    logic [31:0]                 rs2;
    logic [31:0]                 rd;       // word the bus returns
    int                          ack_at;   // 1-based REQ cycle of ack, 0 = never
    logic                        exp_mis;
    logic                        exp_req;
    logic [3:0]                  exp_be;
    logic [31:0]                 exp_wr;
    logic [31:0]                 exp_rd;   // result for loads (masked by size)
    int                          exp_nreq; // cycles dbus_req is high
    logic                        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input RV32I_OPCODE_t op, input RV32I_INSTRUCTION_MNEMONIC_t mn,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rd, input int ack_at,
                              input logic mis, input logic req, input logic [3:0] be,
                              input logic [31:0] wr, input logic [31:0] rdx,
                              input int nreq, input logic err);
    vec_t v;
    v.op = op; v.mn = mn; v.addr = addr; v.rs2 = rs2; v.rd = rd; v.ack_at = ack_at;
    v.exp_mis = mis; v.exp_req = req; v.exp_be = be; v.exp_wr = wr; v.exp_rd = rdx;
    v.exp_nreq = nreq; v.exp_err = err;
    return v;
  endfunction

  task automatic set_nop();
    opcode   = I_TYPE;
    mnemonic = ADDI;
    alu_out  = 32'h0;
    rs2_data = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] prev;
    logic [31:0] mask;
    int          n_req;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    prev          = bus_rddata;
    opcode        = v.op;
    mnemonic      = v.mn;
    alu_out       = v.addr;
    rs2_data      = v.rs2;
    dbus.dbus_ack = 1'b0;
    dbus.dbus_rddata = v.rd;
    #1;
    check({tag, " misaligned"}, 32'(misaligned), 32'(v.exp_mis));
    check({tag, " stall_idle"}, 32'(lsu_stall), 32'(v.exp_req));
    if (!v.exp_req) begin
      @(posedge clk); #1;
      check({tag, " no_req"}, 32'(dbus.dbus_req), 32'd0);
      check({tag, " rddata_kept"}, bus_rddata, prev);
      set_nop();
      return;
    end
    @(posedge clk); #1;
    check({tag, " req"}, 32'(dbus.dbus_req), 32'd1);
    check({tag, " we"}, 32'(dbus.dbus_we), 32'(v.op == S_TYPE));
    check({tag, " be"}, 32'(dbus.dbus_be), 32'(v.exp_be));
    if (v.op == S_TYPE) check({tag, " wrdata"}, dbus.dbus_wrdata, v.exp_wr);
    n_req = 0;
    while (dbus.dbus_req === 1'b1 && n_req < 40) begin
      n_req++;
      check({tag, " stall_req"}, 32'(lsu_stall), 32'd1);
      check({tag, " addr"}, dbus.dbus_addr, {v.addr[31:2], 2'b00});
      dbus.dbus_ack = (n_req == v.ack_at);
      @(posedge clk); #1;
      dbus.dbus_ack = 1'b0;
    end
    // Now in the DONE cycle.
    check({tag, " req_cycles"}, 32'(n_req), 32'(v.exp_nreq));
    check({tag, " stall_done"}, 32'(lsu_stall), 32'd0);
    check({tag, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
    case (v.mn)
      LB, LBU: mask = 32'h0000_00FF;
      LH, LHU: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    if (v.op == S_TYPE) check({tag, " rddata_kept"}, bus_rddata, prev);
    else                check({tag, " rddata"}, bus_rddata & mask, v.exp_rd);
    set_nop();
    @(posedge clk); #1;
    check({tag, " err_cleared"}, 32'(bus_err), 32'd0);
    check({tag, " no_reissue"}, 32'(dbus.dbus_req), 32'd0);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = mk(S_TYPE,      SW,  32'h100, 32'hDEADBEEF, 32'h0,         1, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,         1, 0);
    vecs[1]  = mk(S_TYPE,      SB,  32'h103, 32'h000000A5, 32'h0,         1, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,         1, 0);
    vecs[2]  = mk(S_TYPE,      SH,  32'h102, 32'h1234ABCD, 32'h0,         2, 0, 1, 4'b1100, 32'hABCDABCD, 32'h0,         2, 0);
    vecs[3]  = mk(S_TYPE,      SB,  32'h101, 32'h0000007F, 32'h0,         3, 0, 1, 4'b0010, 32'h7F7F7F7F, 32'h0,         3, 0);
    vecs[4]  = mk(S_TYPE,      SH,  32'h100, 32'hFFFF5678, 32'h0,         1, 0, 1, 4'b0011, 32'h56785678, 32'h0,         1, 0);
    vecs[5]  = mk(I_LOAD_TYPE, LH,  32'h102, 32'h0,        32'h80010000,  4, 0, 1, 4'b1111, 32'h0,        32'h00008001,  4, 0);
    vecs[6]  = mk(I_LOAD_TYPE, LW,  32'h200, 32'h0,        32'hCAFEF00D,  1, 0, 1, 4'b1111, 32'h0,        32'hCAFEF00D,  1, 0);
    vecs[7]  = mk(I_LOAD_TYPE, LBU, 32'h203, 32'h0,        32'h5A000000,  2, 0, 1, 4'b1111, 32'h0,        32'h0000005A,  2, 0);
    vecs[8]  = mk(I_LOAD_TYPE, LB,  32'h201, 32'h0,        32'h0000C300,  1, 0, 1, 4'b1111, 32'h0,        32'h000000C3,  1, 0);
    vecs[9]  = mk(I_LOAD_TYPE, LHU, 32'h200, 32'h0,        32'h1234BEEF,  1, 0, 1, 4'b1111, 32'h0,        32'h0000BEEF,  1, 0);
    vecs[10] = mk(I_LOAD_TYPE, LW,  32'h300, 32'h0,        32'h99999999,  0, 0, 1, 4'b1111, 32'h0,        32'h00000000,  4, 1);
    vecs[11] = mk(I_LOAD_TYPE, LW,  32'h304, 32'h0,        32'h11223344,  4, 0, 1, 4'b1111, 32'h0,        32'h11223344,  4, 0);
    vecs[12] = mk(I_LOAD_TYPE, LW,  32'h101, 32'h0,        32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0);
    vecs[13] = mk(S_TYPE,      SH,  32'h101, 32'h0,        32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0);
    vecs[14] = mk(I_LOAD_TYPE, LHU, 32'h103, 32'h0,        32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0);
    vecs[15] = mk(S_TYPE,      SW,  32'h102, 32'h0,        32'h0,         0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0);
    vecs[16] = mk(R_TYPE,      ADD, 32'h103, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,         0, 0);

    // Reset state.
    rst_n            = 1'b0;
    dbus.dbus_ack    = 1'b0;
    dbus.dbus_rddata = 32'h0;
    set_nop();
    #1;
    check("rst dbus_req", 32'(dbus.dbus_req), 32'd0);
    check("rst dbus_we", 32'(dbus.dbus_we), 32'd0);
    check("rst dbus_addr", dbus.dbus_addr, 32'd0);
    check("rst dbus_be", 32'(dbus.dbus_be), 32'd0);
    check("rst dbus_wrdata", dbus.dbus_wrdata, 32'd0);
    check("rst bus_rddata", bus_rddata, 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);
    check("rst lsu_stall", 32'(lsu_stall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table of single transactions.
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Ack outside REQ must be ignored.
    @(negedge clk);
    begin
      logic [31:0] prev;
      prev = bus_rddata;
      dbus.dbus_ack    = 1'b1;
      dbus.dbus_rddata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ack req", 32'(dbus.dbus_req), 32'd0);
      check("idle_ack rddata", bus_rddata, prev);
      check("idle_ack err", 32'(bus_err), 32'd0);
      dbus.dbus_ack = 1'b0;
    end

    // Reset pulsed mid-REQ, then a normal load.
    @(negedge clk);
    opcode   = I_LOAD_TYPE;
    mnemonic = LW;
    alu_out  = 32'h400;
    @(posedge clk); #1;
    check("mid_rst req_before", 32'(dbus.dbus_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst req_async", 32'(dbus.dbus_req), 32'd0);
    check("mid_rst rddata", bus_rddata, 32'd0);
    check("mid_rst err", 32'(bus_err), 32'd0);
    set_nop();
    #1;
    check("mid_rst stall", 32'(lsu_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(I_LOAD_TYPE, LW, 32'h400, 32'h0, 32'h0BADF00D, 1, 0, 1, 4'b1111, 32'h0,
               32'h0BADF00D, 1, 0), 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
